// File: rtl/regfile_wport_arb_if.sv
// Write-port bundle between the WB stage / multi-cycle unit and the regfile arbiter.
// master = requesters and regfile side, slave = arbiter.
interface regfile_wport_arb_if;
  logic        wa_we;
  logic [4:0]  wa_addr;
  logic [31:0] wa_data;
  logic        mb_valid;
  logic [4:0]  mb_addr;
  logic [31:0] mb_data;
  logic        mb_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic        err;

  modport master (
    output wa_we, wa_addr, wa_data, mb_valid, mb_addr, mb_data,
    input  mb_ready, rf_we, rf_waddr, rf_wdata, stall_req, err
  );

  modport slave (
    input  wa_we, wa_addr, wa_data, mb_valid, mb_addr, mb_data,
    output mb_ready, rf_we, rf_waddr, rf_wdata, stall_req, err
  );
endinterface

// File: rtl/regfile_wport_arb.sv
// Shares the regfile write port between WB (port A, 0-cycle, never stalled) and a valid/ready unit (port B).
// Starved B is force-granted; the displaced A write drains from a one-entry hold while stall_req bubbles the pipe.
module regfile_wport_arb #(
  parameter int STARVE_LIMIT = 4,
  parameter int CW           = 3
) (
  input logic               clk,
  input logic               rst,
  regfile_wport_arb_if.slave bus
);

  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic          hold_valid;
  logic [4:0]    hold_addr;
  logic [31:0]   hold_data;
  logic [CW-1:0] starve_cnt;
  logic          err_q;

  logic a_req, b_req, b_zero;
  logic grant_b, hold_load, err_set;

  assign a_req  = bus.wa_we && (bus.wa_addr != 5'd0);
  assign b_req  = bus.mb_valid && (bus.mb_addr != 5'd0);
  assign b_zero = bus.mb_valid && (bus.mb_addr == 5'd0);

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = 5'd0;
    bus.rf_wdata = 32'd0;
    bus.mb_ready = 1'b0;
    grant_b      = 1'b0;
    hold_load    = 1'b0;
    err_set      = 1'b0;
    if (!rst) begin
      // r0 writes are no-ops, so B can be acked for free in any state
      bus.mb_ready = b_zero;
      if (hold_valid) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = hold_addr;
        bus.rf_wdata = hold_data;
        err_set      = a_req;
      end else if (b_req && (!a_req || starve_cnt == LIMIT)) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.mb_addr;
        bus.rf_wdata = bus.mb_data;
        bus.mb_ready = 1'b1;
        grant_b      = 1'b1;
        hold_load    = a_req;
      end else if (a_req) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.wa_addr;
        bus.rf_wdata = bus.wa_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_addr  <= 5'd0;
      hold_data  <= 32'd0;
      starve_cnt <= '0;
      err_q      <= 1'b0;
    end else begin
      hold_valid <= hold_load;
      if (hold_load) begin
        hold_addr <= bus.wa_addr;
        hold_data <= bus.wa_data;
      end
      if (!b_req || grant_b) starve_cnt <= '0;
      else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
      err_q <= err_q | err_set;
    end
  end

  // Registered state is masked while rst is asserted so outputs read idle from the first reset cycle.
  assign bus.stall_req = hold_valid && !rst;
  assign bus.err       = err_q && !rst;

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Directed cycle-by-cycle vectors for regfile_wport_arb with STARVE_LIMIT=4.
module tb_regfile_wport_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wport_arb_if bus ();

  regfile_wport_arb #(.STARVE_LIMIT(4), .CW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic        wa_we;
    logic [4:0]  wa_addr;
    logic [31:0] wa_data;
    logic        mb_valid;
    logic [4:0]  mb_addr;
    logic [31:0] mb_data;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_rdy;
    logic        e_stall;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];
  int   applied    = 0;
  int   miscompares = 0;

  function automatic vec_t mk(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic mv, input logic [4:0] ma, input logic [31:0] md,
                              input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
                              input logic erdy, input logic est, input logic eerr);
    vec_t v;
    v.rst = r; v.wa_we = we; v.wa_addr = wa; v.wa_data = wd;
    v.mb_valid = mv; v.mb_addr = ma; v.mb_data = md;
    v.e_we = ewe; v.e_addr = ea; v.e_data = ed;
    v.e_rdy = erdy; v.e_stall = est; v.e_err = eerr;
    return v;
  endfunction

  // Drive one cycle's inputs just after posedge, check at negedge, then advance to the next cycle.
  task automatic apply(input vec_t v, input int id);
    rst          = v.rst;
    bus.wa_we    = v.wa_we;
    bus.wa_addr  = v.wa_addr;
    bus.wa_data  = v.wa_data;
    bus.mb_valid = v.mb_valid;
    bus.mb_addr  = v.mb_addr;
    bus.mb_data  = v.mb_data;
    @(negedge clk);
    applied++;
    if (bus.rf_we !== v.e_we || bus.rf_waddr !== v.e_addr || bus.rf_wdata !== v.e_data ||
        bus.mb_ready !== v.e_rdy || bus.stall_req !== v.e_stall || bus.err !== v.e_err) begin
      miscompares++;
      $display("FAIL vec%0d: got we=%b addr=%0d data=%h rdy=%b stall=%b err=%b, want we=%b addr=%0d data=%h rdy=%b stall=%b err=%b",
               id, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.mb_ready, bus.stall_req, bus.err,
               v.e_we, v.e_addr, v.e_data, v.e_rdy, v.e_stall, v.e_err);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.wa_we = 1'b1; bus.wa_addr = 5'd3; bus.wa_data = 32'h1;
    bus.mb_valid = 1'b1; bus.mb_addr = 5'd5; bus.mb_data = 32'h2;

    //          rst we wa     wd            mv ma     md              ewe ea     ed            rdy st er
    // reset with both ports requesting
    tbl.push_back(mk(1, 1, 5'd3, 32'h1,        1, 5'd5, 32'h2,          0, 5'd0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(1, 1, 5'd3, 32'h1,        1, 5'd5, 32'h2,          0, 5'd0, 32'h0,        0, 0, 0));
    // uncontended A, idle, B, idle
    tbl.push_back(mk(0, 1, 5'd3, 32'h11111111, 0, 5'd0, 32'h0,          1, 5'd3, 32'h11111111, 0, 0, 0));
    tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,          0, 5'd0, 32'h0,        0, 0, 0));
    tbl.push_back(mk(0, 0, 5'd0, 32'h0,        1, 5'd5, 32'hDEADBEEF,   1, 5'd5, 32'hDEADBEEF, 1, 0, 0));
    tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,          0, 5'd0, 32'h0,        0, 0, 0));
    // starvation: 4 blocked cycles, forced grant, drain of held r5, then r6
    tbl.push_back(mk(0, 1, 5'd1, 32'hA1,       1, 5'd9, 32'hCAFE0000,   1, 5'd1, 32'hA1,       0, 0, 0));
    tbl.push_back(mk(0, 1, 5'd2, 32'hA2,       1, 5'd9, 32'hCAFE0000,   1, 5'd2, 32'hA2,       0, 0, 0));
    tbl.push_back(mk(0, 1, 5'd3, 32'hA3,       1, 5'd9, 32'hCAFE0000,   1, 5'd3, 32'hA3,       0, 0, 0));
    tbl.push_back(mk(0, 1, 5'd4, 32'hA4,       1, 5'd9, 32'hCAFE0000,   1, 5'd4, 32'hA4,       0, 0, 0));
    tbl.push_back(mk(0, 1, 5'd5, 32'hA5,       1, 5'd9, 32'hCAFE0000,   1, 5'd9, 32'hCAFE0000, 1, 0, 0));
    tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,          1, 5'd5, 32'hA5,       0, 1, 0));
    tbl.push_back(mk(0, 1, 5'd6, 32'hA6,       0, 5'd0, 32'h0,          1, 5'd6, 32'hA6,       0, 0, 0));
    tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,          0, 5'd0, 32'h0,        0, 0, 0));
    // hold violation: A writes r7 in the drain cycle
    tbl.push_back(mk(0, 1, 5'd1, 32'hB1,       1, 5'd9, 32'hCAFE0001,   1, 5'd1, 32'hB1,       0, 0, 0));
    tbl.push_back(mk(0, 1, 5'd2, 32'hB2,       1, 5'd9, 32'hCAFE0001,   1, 5'd2, 32'hB2,       0, 0, 0));
    tbl.push_back(mk(0, 1, 5'd3, 32'hB3,       1, 5'd9, 32'hCAFE0001,   1, 5'd3, 32'hB3,       0, 0, 0));
    tbl.push_back(mk(0, 1, 5'd4, 32'hB4,       1, 5'd9, 32'hCAFE0001,   1, 5'd4, 32'hB4,       0, 0, 0));
    tbl.push_back(mk(0, 1, 5'd5, 32'hB5,       1, 5'd9, 32'hCAFE0001,   1, 5'd9, 32'hCAFE0001, 1, 0, 0));
    tbl.push_back(mk(0, 1, 5'd7, 32'hB7,       0, 5'd0, 32'h0,          1, 5'd5, 32'hB5,       0, 1, 0));
    tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,          0, 5'd0, 32'h0,        0, 0, 1));
    tbl.push_back(mk(0, 1, 5'd6, 32'hB6,       0, 5'd0, 32'h0,          1, 5'd6, 32'hB6,       0, 0, 1));
    // address 0: B to r0 acked under A traffic without hold; A to r0 alone is no write
    tbl.push_back(mk(0, 1, 5'd2, 32'hC2,       1, 5'd0, 32'hFFFF,       1, 5'd2, 32'hC2,       1, 0, 1));
    tbl.push_back(mk(0, 1, 5'd2, 32'hC3,       1, 5'd0, 32'hFFFF,       1, 5'd2, 32'hC3,       1, 0, 1));
    tbl.push_back(mk(0, 1, 5'd0, 32'h1234,     0, 5'd0, 32'h0,          0, 5'd0, 32'h0,        0, 0, 1));
    // reset clears sticky err
    tbl.push_back(mk(1, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,          0, 5'd0, 32'h0,        0, 0, 0));

    @(posedge clk);
    #1;
    foreach (tbl[i]) apply(tbl[i], i);

    // Reset in the drain cycle discards the held write.
    for (int k = 0; k < 4; k++)
      apply(mk(0, 1, 5'(k + 1), 32'hD0 + k, 1, 5'd10, 32'h0BADF00D, 1, 5'(k + 1), 32'hD0 + k, 0, 0, 0), 100 + k);
    apply(mk(0, 1, 5'd5, 32'hD5, 1, 5'd10, 32'h0BADF00D, 1, 5'd10, 32'h0BADF00D, 1, 0, 0), 104);
    apply(mk(1, 0, 5'd0, 32'h0,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0), 105);
    apply(mk(0, 0, 5'd0, 32'h0,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0), 106);

    // Build up starvation, reset mid-way, then a full STARVE_LIMIT of blocked cycles is needed again.
    apply(mk(0, 1, 5'd11, 32'hE1, 1, 5'd12, 32'h12121212, 1, 5'd11, 32'hE1, 0, 0, 0), 107);
    apply(mk(0, 1, 5'd11, 32'hE2, 1, 5'd12, 32'h12121212, 1, 5'd11, 32'hE2, 0, 0, 0), 108);
    apply(mk(0, 1, 5'd11, 32'hE3, 1, 5'd12, 32'h12121212, 1, 5'd11, 32'hE3, 0, 0, 0), 109);
    apply(mk(1, 1, 5'd11, 32'hE4, 1, 5'd12, 32'h12121212, 0, 5'd0,  32'h0,  0, 0, 0), 110);
    for (int k = 0; k < 4; k++)
      apply(mk(0, 1, 5'd13, 32'hF0 + k, 1, 5'd12, 32'h12121212, 1, 5'd13, 32'hF0 + k, 0, 0, 0), 111 + k);
    apply(mk(0, 1, 5'd14, 32'hF4, 1, 5'd12, 32'h12121212, 1, 5'd12, 32'h12121212, 1, 0, 0), 115);
    apply(mk(0, 0, 5'd0,  32'h0,  0, 5'd0,  32'h0,        1, 5'd14, 32'hF4,       0, 1, 0), 116);
    apply(mk(0, 0, 5'd0,  32'h0,  0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 0, 0), 117);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
